// File: rtl/alu_seq.sv
// alu_seq: registered WIDTH-bit ALU with valid/ready handshakes and carry chaining.
// Define ALU_SEQ_MUL_EN to build the iterative shift-add multiplier (opcode 13).
module alu_seq #(
  parameter int WIDTH = 16,
  localparam int SHW = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] arg_a,
  input  logic [WIDTH-1:0] arg_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             carry,
  output logic             zero,
  output logic             negative,
  output logic             overflow,
  output logic             busy
);

  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_SUB = 4'd1;
  localparam logic [3:0] OP_AND = 4'd2;
  localparam logic [3:0] OP_OR  = 4'd3;
  localparam logic [3:0] OP_NOT = 4'd4;
  localparam logic [3:0] OP_XOR = 4'd5;
  localparam logic [3:0] OP_ROL = 4'd6;
  localparam logic [3:0] OP_ROR = 4'd7;
  localparam logic [3:0] OP_ADC = 4'd8;
  localparam logic [3:0] OP_SBB = 4'd9;
  localparam logic [3:0] OP_SHL = 4'd10;
  localparam logic [3:0] OP_SHR = 4'd11;
  localparam logic [3:0] OP_ASR = 4'd12;
  localparam logic [3:0] OP_MUL = 4'd13;
  localparam logic [3:0] OP_CMP = 4'd14;
  localparam logic [3:0] OP_PSB = 4'd15;

  localparam int M = WIDTH - 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_HOLD = 2'd1
`ifdef ALU_SEQ_MUL_EN
    , S_MUL = 2'd2
`endif
  } state_t;

  state_t state, state_nx;
  logic   cf;
  logic   accept, is_mul, ld_res;

  logic [WIDTH-1:0]   r_c;
  logic               c_c, z_c, n_c, v_c;
  logic               cin, nz;
  logic [SHW-1:0]     sh;
  logic [WIDTH:0]     sum, diff;
  logic [WIDTH:0]     shl_x, shr_x, asr_x;
  logic [2*WIDTH-1:0] rol_x, ror_x;
  logic               add_ovf, sub_ovf;

  assign accept    = in_valid && in_ready;
  assign ld_res    = accept && !is_mul;
  assign out_valid = (state == S_HOLD);
  assign in_ready  = (state == S_IDLE) ||
                     ((state == S_HOLD) && out_ready);

`ifdef ALU_SEQ_MUL_EN
  logic [2*WIDTH-1:0] ma, acc, acc_nx;
  logic [WIDTH-1:0]   mb;
  logic [SHW-1:0]     cnt;
  logic               last;

  assign is_mul = (op == OP_MUL);
  assign busy   = (state == S_MUL);
  assign last   = (state == S_MUL) && (cnt == SHW'(WIDTH-1));
  assign acc_nx = acc + (mb[cnt] ? (ma << cnt) : '0);
`else
  assign is_mul = 1'b0;
  assign busy   = 1'b0;
`endif

  always_comb begin
    state_nx = state;
    if (accept) state_nx = S_HOLD;
`ifdef ALU_SEQ_MUL_EN
    if (accept && is_mul) state_nx = S_MUL;
    if (last) state_nx = S_HOLD;
`endif
    if ((state == S_HOLD) && out_ready && !in_valid)
      state_nx = S_IDLE;
  end

  // Single-cycle datapath; cin is the carry flag only for the chained ops.
  always_comb begin
    cin   = (op == OP_ADC || op == OP_SBB) ? cf : 1'b0;
    sh    = arg_b[SHW-1:0];
    nz    = (sh != '0);
    sum   = {1'b0, arg_a} + {1'b0, arg_b} + (WIDTH+1)'(cin);
    diff  = {1'b0, arg_a} - {1'b0, arg_b} - (WIDTH+1)'(cin);
    shl_x = {1'b0, arg_a} << sh;
    shr_x = {arg_a, 1'b0} >> sh;
    asr_x = $signed({arg_a, 1'b0}) >>> sh;
    rol_x = {arg_a, arg_a} << sh;
    ror_x = {arg_a, arg_a} >> sh;
    add_ovf = (arg_a[M] == arg_b[M]) && (sum[M] != arg_a[M]);
    sub_ovf = (arg_a[M] != arg_b[M]) && (diff[M] != arg_a[M]);
    r_c = '0;
    c_c = 1'b0;
    v_c = 1'b0;
    unique case (op)
      OP_ADD, OP_ADC: begin
        r_c = sum[M:0]; c_c = sum[WIDTH]; v_c = add_ovf;
      end
      OP_SUB, OP_SBB, OP_CMP: begin
        r_c = diff[M:0]; c_c = diff[WIDTH]; v_c = sub_ovf;
      end
      OP_AND: r_c = arg_a & arg_b;
      OP_OR:  r_c = arg_a | arg_b;
      OP_NOT: r_c = ~arg_a;
      OP_XOR: r_c = arg_a ^ arg_b;
      OP_ROL: begin
        r_c = rol_x[2*WIDTH-1:WIDTH]; c_c = nz & rol_x[WIDTH];
      end
      OP_ROR: begin
        r_c = ror_x[M:0]; c_c = nz & ror_x[M];
      end
      OP_SHL: begin
        r_c = shl_x[M:0]; c_c = shl_x[WIDTH];
      end
      OP_SHR: begin
        r_c = shr_x[WIDTH:1]; c_c = shr_x[0];
      end
      OP_ASR: begin
        r_c = asr_x[WIDTH:1]; c_c = asr_x[0];
      end
      OP_MUL: r_c = '0;
      OP_PSB: r_c = arg_b;
      default: r_c = '0;
    endcase
    z_c = (r_c == '0);
    n_c = r_c[M];
    if (op == OP_CMP) begin
      r_c = arg_a;
      z_c = (arg_a == arg_b);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      result   <= '0;
      carry    <= 1'b0;
      zero     <= 1'b0;
      negative <= 1'b0;
      overflow <= 1'b0;
      cf       <= 1'b0;
`ifdef ALU_SEQ_MUL_EN
      ma  <= '0;
      mb  <= '0;
      acc <= '0;
      cnt <= '0;
`endif
    end else begin
      state <= state_nx;
      if (ld_res) begin
        result   <= r_c;
        carry    <= c_c;
        zero     <= z_c;
        negative <= n_c;
        overflow <= v_c;
        cf       <= c_c;
      end
`ifdef ALU_SEQ_MUL_EN
      if (accept && is_mul) begin
        ma  <= {{WIDTH{1'b0}}, arg_a};
        mb  <= arg_b;
        acc <= '0;
        cnt <= '0;
      end else if (state == S_MUL) begin
        acc <= acc_nx;
        cnt <= cnt + SHW'(1);
      end
      // Final step: carry flags a non-zero upper product half.
      if (last) begin
        result   <= acc_nx[M:0];
        carry    <= |acc_nx[2*WIDTH-1:WIDTH];
        zero     <= (acc_nx[M:0] == '0);
        negative <= acc_nx[M];
        overflow <= 1'b0;
        cf       <= |acc_nx[2*WIDTH-1:WIDTH];
      end
`endif
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: directed vectors for alu_seq with a queue scoreboard.
// The multiply section follows ALU_SEQ_MUL_EN.
module tb_alu_seq;
  localparam int W = 16;

  localparam logic [3:0] ADD = 4'd0;
  localparam logic [3:0] SUB = 4'd1;
  localparam logic [3:0] AND = 4'd2;
  localparam logic [3:0] OR  = 4'd3;
  localparam logic [3:0] NOT = 4'd4;
  localparam logic [3:0] XOR = 4'd5;
  localparam logic [3:0] ROL = 4'd6;
  localparam logic [3:0] ROR = 4'd7;
  localparam logic [3:0] ADC = 4'd8;
  localparam logic [3:0] SBB = 4'd9;
  localparam logic [3:0] SHL = 4'd10;
  localparam logic [3:0] SHR = 4'd11;
  localparam logic [3:0] ASR = 4'd12;
  localparam logic [3:0] MUL = 4'd13;
  localparam logic [3:0] CMP = 4'd14;
  localparam logic [3:0] PSB = 4'd15;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         out_ready = 1'b1;
  logic [3:0]   op = '0;
  logic [W-1:0] arg_a = '0;
  logic [W-1:0] arg_b = '0;
  logic         in_ready, out_valid;
  logic         carry, zero, negative, overflow, busy;
  logic [W-1:0] result;

  int total = 0;
  int bad = 0;
  int cyc = 0;

  typedef struct packed {
    logic [W-1:0] r;
    logic c, z, n, v;
  } exp_t;

  exp_t sbq[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  alu_seq #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .arg_a(arg_a), .arg_b(arg_b),
    .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .carry(carry), .zero(zero),
    .negative(negative), .overflow(overflow), .busy(busy)
  );

  function automatic exp_t mk(input logic [W-1:0] r,
                              input logic c, z, n, v);
    exp_t e;
    e.r = r; e.c = c; e.z = z; e.n = n; e.v = v;
    return e;
  endfunction

  task automatic check(input string nm, input logic [31:0] act,
                       input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, req);
    end
  endtask

  // Monitor: every result the consumer takes is matched against the queue.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (sbq.size() == 0) begin
        check("sb_extra_result", 32'(sbq.size()), 1);
      end else begin
        exp_t e;
        e = sbq.pop_front();
        check("sb_result", 32'(result), 32'(e.r));
        check("sb_flags_cznv", {carry, zero, negative, overflow},
              {e.c, e.z, e.n, e.v});
      end
    end
  end

  task automatic issue(input logic [3:0] o, input logic [W-1:0] a,
                       input logic [W-1:0] b, input exp_t e,
                       input bit push);
    int n;
    n = 0;
    if (push) sbq.push_back(e);
    op = o; arg_a = a; arg_b = b; in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && n < 100) begin
      n++;
      @(negedge clk);
    end
    if (n >= 100) check("accept_timeout", 32'(n), 0);
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  initial begin
    int k, bh, t0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_out_valid", 32'(out_valid), 0);
    check("rst_result", 32'(result), 0);
    check("rst_flags", {carry, zero, negative, overflow, busy}, 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    check("rst_in_ready", 32'(in_ready), 1);

    issue(ADD, 16'hFFFF, 16'h0001, mk(16'h0000, 1, 1, 0, 0), 1);
    check("add_latency", 32'(out_valid), 1);
    issue(ADC, 16'h0001, 16'h0001, mk(16'h0003, 0, 0, 0, 0), 1);
    issue(SUB, 16'h0003, 16'h0005, mk(16'hFFFE, 1, 0, 1, 0), 1);
    issue(CMP, 16'h8000, 16'h0001, mk(16'h8000, 0, 0, 0, 1), 1);
    issue(ROL, 16'h8001, 16'h0001, mk(16'h0003, 1, 0, 0, 0), 1);
    issue(SHR, 16'h8001, 16'h0004, mk(16'h0800, 0, 0, 0, 0), 1);
    issue(ASR, 16'h8000, 16'h000F, mk(16'hFFFF, 0, 0, 1, 0), 1);
    issue(ROR, 16'h1234, 16'h0000, mk(16'h1234, 0, 0, 0, 0), 1);
    issue(SUB, 16'h0000, 16'h0001, mk(16'hFFFF, 1, 0, 1, 0), 1);
    issue(SBB, 16'h0010, 16'h0001, mk(16'h000E, 0, 0, 0, 0), 1);
    issue(AND, 16'hF0F0, 16'h0FF0, mk(16'h00F0, 0, 0, 0, 0), 1);
    issue(OR,  16'hF000, 16'h000F, mk(16'hF00F, 0, 0, 1, 0), 1);
    issue(NOT, 16'h00FF, 16'h1234, mk(16'hFF00, 0, 0, 1, 0), 1);
    issue(SHL, 16'h8001, 16'h0001, mk(16'h0002, 1, 0, 0, 0), 1);
    issue(ADC, 16'h7FFF, 16'h0000, mk(16'h8000, 0, 0, 1, 1), 1);
    issue(CMP, 16'h4444, 16'h4444, mk(16'h4444, 0, 1, 0, 0), 1);

`ifdef ALU_SEQ_MUL_EN
    issue(MUL, 16'h0123, 16'h0010, mk(16'h1230, 0, 0, 0, 0), 1);
    k = 0; bh = 0;
    while (!out_valid && k < 40) begin
      if (busy) bh++;
      @(posedge clk);
      #1 k++;
    end
    check("mul_latency", 32'(k), 16);
    check("mul_busy_cycles", 32'(bh), 16);
    check("mul_busy_done", 32'(busy), 0);

    issue(MUL, 16'h1000, 16'h0010, mk(16'h0000, 1, 1, 0, 0), 1);
    k = 0;
    while (!out_valid && k < 40) begin
      @(posedge clk);
      #1 k++;
    end
    check("mul2_latency", 32'(k), 16);

    issue(MUL, 16'hFFFF, 16'hFFFF, '0, 0);
    repeat (4) @(posedge clk);
    #1 rst_n = 1'b0;
    @(posedge clk);
    #1;
    check("abort_out_valid", 32'(out_valid), 0);
    check("abort_busy", 32'(busy), 0);
    check("abort_in_ready", 32'(in_ready), 1);
    rst_n = 1'b1;
    issue(ADD, 16'h0002, 16'h0003, mk(16'h0005, 0, 0, 0, 0), 1);
    issue(ADC, 16'h0001, 16'h0001, mk(16'h0002, 0, 0, 0, 0), 1);
`else
    issue(ADD, 16'hFFFF, 16'h0001, mk(16'h0000, 1, 1, 0, 0), 1);
    issue(MUL, 16'h0123, 16'h0010, mk(16'h0000, 0, 1, 0, 0), 1);
    check("mul_off_latency", 32'(out_valid), 1);
    check("mul_off_busy", 32'(busy), 0);
    issue(ADC, 16'h0001, 16'h0001, mk(16'h0002, 0, 0, 0, 0), 1);
`endif

    repeat (2) @(posedge clk);
    #1 out_ready = 1'b0;
    issue(XOR, 16'hF0F0, 16'hFFFF, mk(16'h0F0F, 0, 0, 0, 0), 1);
    op = PSB; arg_a = '0; arg_b = 16'h5555; in_valid = 1'b1;
    repeat (5) begin
      @(negedge clk);
      check("bp_result", 32'(result), 32'h0F0F);
      check("bp_in_ready", 32'(in_ready), 0);
    end
    @(posedge clk);
    #1 out_ready = 1'b1;
    issue(PSB, 16'h0000, 16'h5555, mk(16'h5555, 0, 0, 0, 0), 1);

    t0 = cyc;
    issue(ADD, 16'h0001, 16'h0001, mk(16'h0002, 0, 0, 0, 0), 1);
    issue(ADD, 16'h7FFF, 16'h0001, mk(16'h8000, 0, 0, 1, 1), 1);
    issue(ADD, 16'h8000, 16'h8000, mk(16'h0000, 1, 1, 0, 1), 1);
    issue(ADD, 16'h1234, 16'h4321, mk(16'h5555, 0, 0, 0, 0), 1);
    check("stream_cycles", 32'(cyc - t0), 4);

    repeat (3) @(posedge clk);
    #1;
    check("sb_empty", 32'(sbq.size()), 0);
    check("idle_out_valid", 32'(out_valid), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/alu_seq.md
Name: alu_seq

Overview:
- Parametrised, registered successor to the 3-bit-op combinational ALU.
- Features:
  - width set by `WIDTH`
  - 4-bit opcode space, with the original eight ops kept at codes 0-7
  - shift/rotate by N bits
  - carry-chained ADC/SBB using an internal carry flag
  - optional iterative multiply
- Sits between the register-file read stage and writeback, using valid/ready handshakes on both sides.

Parameters:
- WIDTH, 16, datapath width; must be a power of two and at least 4.
- SHW, $clog2(WIDTH), shift-amount width; derived, not overridden.

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  synchronous active-low reset.
- in_valid  input  1  request valid.
- in_ready  output  1  block can accept a request this cycle.
- op  input  4  operation code.
- arg_a  input  WIDTH  operand A.
- arg_b  input  WIDTH  operand B; for shifts and rotates, the amount is arg_b[SHW-1:0].
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts the result.
- result  output  WIDTH  registered result.
- carry  output  1  registered carry/borrow flag.
- zero  output  1  registered flag, result == 0.
- negative  output  1  registered flag, result[WIDTH-1].
- overflow  output  1  registered signed-overflow flag.
- busy  output  1  multiply in progress.

Behaviour:
- Reset and handshake:
  - Reset (synchronous, rst_n low at a clk edge) drives every output to 0, clears the internal carry flag cf, sets the state to IDLE and discards any operation in flight, including a multiply mid-iteration.
  - A request is accepted when in_valid && in_ready. A result is consumed when out_valid && out_ready.
- Opcodes:
  - 0 ADD; 1 SUB; 2 AND; 3 OR; 4 NOT (uses A only); 5 XOR.
  - 6 ROL and 7 ROR rotate A by the shift amount. These differ from the original, which always rotated by 1.
  - 8 ADC computes A+B+cf; 9 SBB computes A-B-cf.
  - 10 SHL and 11 SHR are logical shifts of A; 12 ASR is an arithmetic shift of A.
  - 13 MUL gives the low WIDTH bits of A*B, unsigned.
  - 14 CMP sets flags as for SUB, and result = A.
  - 15 PASSB gives result = B.
- Flags:
  - zero = (result == 0) for all ops except CMP, where zero = (A == B).
  - negative = result[WIDTH-1]; for CMP it is the MSB of A-B.
  - Carry by op:
    - ADD/ADC: carry-out of the WIDTH+1-bit sum.
    - SUB/SBB/CMP: borrow, i.e. (B+cf_in) > A, where cf_in is 0 for SUB and CMP.
    - Shifts and rotates: the last bit shifted out. Amount 0 gives carry 0 and result = A.
    - MUL: 1 if the upper WIDTH bits of the product are non-zero.
    - Logic ops and PASSB: 0.
  - overflow is two's-complement overflow for ADD/ADC/SUB/SBB/CMP, and 0 otherwise.
- cf is loaded with the carry output whenever a result is registered. ADC/SBB sample cf at acceptance.
- State machine, IDLE/MUL/HOLD:
  - IDLE: in_ready = 1.
    - Accepting a non-MUL op registers the result and flags at the next edge and moves to HOLD, so latency is 1.
    - Accepting MUL latches the operands, clears the accumulator and moves to MUL with the counter at 0.
  - MUL: busy = 1, in_ready = 0.
    - Each cycle does one shift-add step, using B bit `cnt`.
    - When `cnt` reaches WIDTH-1, the final step registers the result and moves to HOLD, so out_valid rises WIDTH cycles after the acceptance edge.
  - HOLD: out_valid = 1, and result and flags stay stable until consumed.
    - in_ready = out_ready, so a simultaneous consume and accept gives back-to-back throughput of 1 op per cycle for non-MUL ops.
    - Consume without a new accept moves to IDLE and clears out_valid.
    - Consume with a MUL accept moves to MUL.
- Result and flag registers hold their last values after consumption; only out_valid drops.
- in_valid while in_ready = 0 is ignored. The requester must hold the request.

Optional Feature:
- Macro: ALU_SEQ_MUL_EN.
- Defined: MUL behaves as above, and the MUL state and counter exist.
- Undefined: the MUL state is not built and busy is tied to 0. Opcode 13 completes in 1 cycle with result = 0, carry = 0, zero = 1, negative = 0, overflow = 0, and cf is cleared.

Test Plan:
- Carry chain: reset, then ADD 0xFFFF+0x0001, then ADC 0x0001+0x0001.
  - ADD gives result 0x0000, carry = 1, zero = 1, out_valid one cycle after accept.
  - The following ADC gives 0x0003, carry = 0.
- SUB 0x0003-0x0005 -> 0xFFFE, carry = 1, negative = 1, overflow = 0.
- CMP 0x8000,0x0001 -> result 0x8000, overflow = 1, negative = 0, zero = 0.
- Shifts and rotates:
  - ROL 0x8001 by 1 -> 0x0003, carry = 1.
  - SHR 0x8001 by 4 -> 0x0800, carry = 0.
  - ASR 0x8000 by 15 -> 0xFFFF, carry = 0.
  - ROR 0x1234 by 0 -> 0x1234, carry = 0.
- Multiply and abort (macro defined):
  - MUL 0x0123*0x0010 -> 0x1230, carry = 0, with out_valid exactly 16 cycles after accept and busy high throughout.
  - MUL 0x1000*0x0010 -> 0x0000, carry = 1, zero = 1.
  - rst_n low at cycle 5 of a MUL -> next cycle out_valid = 0, busy = 0, in_ready = 1, and a fresh ADD works.
- Backpressure:
  - Hold out_ready = 0 for 5 cycles after an XOR 0xF0F0^0xFFFF (= 0x0F0F). Result stays 0x0F0F, in_ready stays 0, and a pending request is not taken.
  - Then streaming 4 ADDs with out_ready = 1 gives one result per cycle.
